// File: rtl/exibe_sequencia_if.sv
// rtl/exibe_sequencia_if.sv - controller/ROM/LED bus of the sequence presenter
interface exibe_sequencia_if;
  logic       iniciar;
  logic       cancela;
  logic [3:0] rodada;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [2:0] db_estado;
  logic [3:0] db_endereco;

  // Controller / ROM side: drives requests and ROM data, observes the display.
  modport master (
    output iniciar, cancela, rodada, dado,
    input  endereco, leds, exibindo, pronto, db_estado, db_endereco
  );

  // Presenter side.
  modport slave (
    input  iniciar, cancela, rodada, dado,
    output endereco, leds, exibindo, pronto, db_estado, db_endereco
  );
endinterface

// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - shows ROM entries 0..rodada on the leds, then pulses pronto
module exibe_sequencia #(
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500,
  parameter int TW        = 12
) (
  input logic               clock,
  input logic               reset,
  exibe_sequencia_if.slave  bus
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LE      = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam logic [TW-1:0] L_ACESO_FIM   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] L_APAGADO_FIM = TW'(T_APAGADO - 1);

  estado_t       r_estado;
  estado_t       w_prox_estado;
  logic [3:0]    r_endereco;
  logic [3:0]    w_prox_endereco;
  logic [3:0]    r_leds;
  logic [3:0]    w_prox_leds;
  logic [3:0]    r_limite;
  logic [3:0]    w_prox_limite;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_prox_timer;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_endereco <= 4'd0;
      r_leds     <= 4'd0;
      r_limite   <= 4'd0;
      r_timer    <= '0;
    end else begin
      r_estado   <= w_prox_estado;
      r_endereco <= w_prox_endereco;
      r_leds     <= w_prox_leds;
      r_limite   <= w_prox_limite;
      r_timer    <= w_prox_timer;
    end
  end

  // Next-state and next-register logic; cancela overrides every transition.
  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_endereco = r_endereco;
    w_prox_leds     = r_leds;
    w_prox_limite   = r_limite;
    w_prox_timer    = r_timer;

    case (r_estado)
      OCIOSO: begin
        w_prox_leds     = 4'd0;
        w_prox_endereco = 4'd0;
        if (bus.iniciar) begin
          w_prox_limite = bus.rodada;
          w_prox_timer  = '0;
          w_prox_estado = LE;
        end
      end
      LE: begin
        // ROM output for the current address has settled by now.
        w_prox_leds   = bus.dado;
        w_prox_timer  = '0;
        w_prox_estado = ACESO;
      end
      ACESO: begin
        if (r_timer == L_ACESO_FIM) begin
          w_prox_leds   = 4'd0;
          w_prox_timer  = '0;
          w_prox_estado = APAGADO;
        end else begin
          w_prox_timer = r_timer + TW'(1);
        end
      end
      APAGADO: begin
        w_prox_leds = 4'd0;
        if (r_timer == L_APAGADO_FIM) begin
          w_prox_timer  = '0;
          w_prox_estado = PROXIMO;
        end else begin
          w_prox_timer = r_timer + TW'(1);
        end
      end
      PROXIMO: begin
        // Compare before incrementing so the address never wraps past 15.
        if (r_endereco == r_limite) begin
          w_prox_estado = FIM;
        end else begin
          w_prox_endereco = r_endereco + 4'd1;
          w_prox_estado   = LE;
        end
      end
      FIM: begin
        w_prox_endereco = 4'd0;
        w_prox_leds     = 4'd0;
        w_prox_estado   = OCIOSO;
      end
      default: begin
        w_prox_endereco = 4'd0;
        w_prox_leds     = 4'd0;
        w_prox_timer    = '0;
        w_prox_estado   = OCIOSO;
      end
    endcase

    if (bus.cancela) begin
      w_prox_estado   = OCIOSO;
      w_prox_endereco = 4'd0;
      w_prox_leds     = 4'd0;
      w_prox_timer    = '0;
      w_prox_limite   = r_limite;
    end
  end

  assign bus.endereco    = r_endereco;
  assign bus.leds        = r_leds;
  assign bus.exibindo    = (r_estado != OCIOSO);
  assign bus.pronto      = (r_estado == FIM);
  assign bus.db_estado   = r_estado;
  assign bus.db_endereco = r_endereco;

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb/tb_exibe_sequencia.sv - scoreboard bench for exibe_sequencia
module tb_exibe_sequencia;
  localparam int TA = 4;
  localparam int TP = 2;
  localparam int PER = TA + TP + 2;

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] endr;
    logic       exi;
    logic       pro;
  } esp_t;

  logic clock = 1'b0;
  logic reset;
  int   n_testes = 0;
  int   n_falhas = 0;
  int   ciclo    = 0;
  esp_t sb[$];

  exibe_sequencia_if bus();

  exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP), .TW(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ROM model: each address holds address+1.
  assign bus.dado = bus.endereco + 4'd1;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  function automatic esp_t modelo(input int r, input int k);
    esp_t e;
    int   i;
    int   p;
    e = '0;
    if (k < (r + 1) * PER) begin
      i      = k / PER;
      p      = k % PER;
      e.exi  = 1'b1;
      e.endr = 4'(i);
      e.leds = (p >= 1 && p <= TA) ? 4'(i + 1) : 4'd0;
    end else if (k == (r + 1) * PER) begin
      e.exi  = 1'b1;
      e.pro  = 1'b1;
      e.endr = 4'(r);
    end
    return e;
  endfunction

  task automatic tick();
    esp_t e;
    @(posedge clock);
    #1;
    ciclo++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      verifica($sformatf("leds c=%0d", ciclo), 32'(bus.leds), 32'(e.leds));
      verifica($sformatf("endereco c=%0d", ciclo), 32'(bus.endereco), 32'(e.endr));
      verifica($sformatf("exibindo c=%0d", ciclo), 32'(bus.exibindo), 32'(e.exi));
      verifica($sformatf("pronto c=%0d", ciclo), 32'(bus.pronto), 32'(e.pro));
    end
  endtask

  // modo 0: plain run; 1: rodada change + iniciar mid-run; 2: cancela during third entry
  task automatic executa(input int r, input int modo, input int npush);
    int       k;
    const int ncanc = 2 * PER + 2;
    for (int j = 0; j < npush; j++) begin
      if (modo == 2 && j > ncanc) sb.push_back('0);
      else sb.push_back(modelo(r, j));
    end
    bus.rodada  = 4'(r);
    bus.iniciar = 1'b1;
    k = 0;
    while (sb.size() > 0 && k < 400) begin
      tick();
      bus.iniciar = 1'b0;
      if (modo == 1 && k == 10) begin
        bus.rodada  = 4'd15;
        bus.iniciar = 1'b1;
      end
      if (modo == 2) bus.cancela = (k == ncanc);
      k++;
    end
    bus.iniciar = 1'b0;
    bus.cancela = 1'b0;
    verifica("timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observado=timeout esperado=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    bus.cancela = 1'b0;
    bus.rodada  = 4'd0;
    #12;
    verifica("rst leds", 32'(bus.leds), 32'd0);
    verifica("rst endereco", 32'(bus.endereco), 32'd0);
    verifica("rst exibindo", 32'(bus.exibindo), 32'd0);
    verifica("rst pronto", 32'(bus.pronto), 32'd0);
    verifica("rst estado", 32'(bus.db_estado), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    tick();

    // Reset mid-ACESO of a rodada=3 run, asynchronously.
    executa(3, 0, PER + 2);
    #2;
    reset = 1'b0;
    #1;
    verifica("arst leds", 32'(bus.leds), 32'd0);
    verifica("arst endereco", 32'(bus.endereco), 32'd0);
    verifica("arst exibindo", 32'(bus.exibindo), 32'd0);
    verifica("arst pronto", 32'(bus.pronto), 32'd0);
    verifica("arst estado", 32'(bus.db_estado), 32'd0);
    tick();
    tick();
    verifica("arst hold exibindo", 32'(bus.exibindo), 32'd0);
    reset = 1'b1;
    tick();

    executa(0, 0, 1 * PER + 4);
    tick();
    executa(3, 1, 4 * PER + 4);
    tick();
    executa(3, 2, 4 * PER + 4);
    tick();
    executa(15, 0, 16 * PER + 4);
    tick();

    // cancela and iniciar together while idle: stays idle.
    for (int j = 0; j < 4; j++) sb.push_back('0);
    bus.rodada  = 4'd5;
    bus.cancela = 1'b1;
    bus.iniciar = 1'b1;
    tick();
    bus.cancela = 1'b0;
    bus.iniciar = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    verifica("idle drain", 32'(sb.size()), 32'd0);

    executa(1, 0, 2 * PER + 4);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end
endmodule
